// File: rtl/freq_bcd_hold_if.sv
// Sample/result bundle between the frequency counter, the BCD hold stage and the digit scanner.
interface freq_bcd_hold_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] freq_data;
  logic              freq_valid;
  logic [15:0]       bcd_out;
  logic              bcd_valid;
  logic              busy;

  modport master (
    output freq_data, freq_valid,
    input  bcd_out, bcd_valid, busy
  );

  modport slave (
    input  freq_data, freq_valid,
    output bcd_out, bcd_valid, busy
  );
endinterface

// File: rtl/freq_bcd_hold.sv
// Samples the binary frequency once per refresh tick, double-dabbles it into four BCD digits and holds them.
// Result visible 13 cycles after the sample cycle; a due sample waits for freq_valid indefinitely, no backpressure.
module freq_bcd_hold #(
  parameter int REFRESH_CNT = 25_000_000,
  parameter int DATA_W      = 12
) (
  input logic            clk,
  input logic            rst,
  freq_bcd_hold_if.slave bus
);
  localparam int CNT_W  = $clog2(REFRESH_CNT);
  localparam int ITER_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic                pending;
  logic                sample;
  logic                last_iter;
  logic [ITER_W-1:0]   iter;
  logic [DATA_W-1:0]   bin_sr;
  logic [DATA_W-1:0]   bin_nxt;
  logic [15:0]         bcd_sr;
  logic [15:0]         bcd_corr;
  logic [15:0]         bcd_nxt;
  logic [15+DATA_W:0]  shifted;

  assign tick      = (cnt == CNT_W'(REFRESH_CNT - 1));
  assign sample    = (state == IDLE) && pending && bus.freq_valid;
  assign last_iter = (iter == ITER_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A tick coinciding with the sample re-arms pending so that refresh is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b1;
    end else if (sample) begin
      pending <= tick;
    end else if (tick) begin
      pending <= 1'b1;
    end
  end

  always_comb begin
    bcd_corr = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_corr[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_corr, bin_sr} << 1;
    bcd_nxt = shifted[15+DATA_W -: 16];
    bin_nxt = shifted[DATA_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample) state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_sr        <= '0;
      bcd_sr        <= '0;
      iter          <= '0;
      bus.bcd_out   <= '0;
      bus.bcd_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.bcd_valid <= (state_nxt == DONE);
      bus.busy      <= (state_nxt != IDLE);
      if (sample) begin
        bin_sr <= bus.freq_data;
        bcd_sr <= '0;
        iter   <= '0;
      end else if (state == SHIFT) begin
        bin_sr <= bin_nxt;
        bcd_sr <= bcd_nxt;
        iter   <= iter + ITER_W'(1);
        // Published together with the DONE cycle so bcd_valid and the new digits coincide.
        if (last_iter) begin
          bus.bcd_out <= bcd_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_freq_bcd_hold.sv
// Self-checking bench for freq_bcd_hold with a cycle-level behavioural reference model.
module tb_freq_bcd_hold;
  localparam int RC = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  freq_bcd_hold_if #(.DATA_W(12)) bus ();

  freq_bcd_hold #(.REFRESH_CNT(RC), .DATA_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: a refresh timer, a pending flag and a remaining-busy countdown.
  int          m_cnt;
  int          m_rem;
  logic        m_pend;
  logic [11:0] m_hold;
  logic [15:0] exp_out;
  logic        exp_val;
  logic        exp_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt    <= 0;
      m_rem    <= 0;
      m_pend   <= 1'b1;
      exp_out  <= 16'h0000;
      exp_val  <= 1'b0;
      exp_busy <= 1'b0;
    end else begin : step
      logic        t;
      int          rem;
      logic        pend;
      logic [11:0] hold;
      t    = (m_cnt == RC - 1);
      rem  = m_rem;
      pend = m_pend;
      hold = m_hold;
      if (rem == 0) begin
        if (pend && bus.freq_valid) begin
          hold = bus.freq_data;
          rem  = 13;
          pend = t;
        end else if (t) begin
          pend = 1'b1;
        end
      end else begin
        rem = rem - 1;
        if (t) pend = 1'b1;
      end
      m_cnt    <= (m_cnt + 1) % RC;
      m_rem    <= rem;
      m_pend   <= pend;
      m_hold   <= hold;
      exp_busy <= (rem > 0);
      exp_val  <= (rem == 1);
      if (rem == 1) exp_out <= to_bcd(int'(hold));
    end
  end

  task automatic test_reset();
    bus.freq_valid = 1'b0;
    bus.freq_data  = 12'd0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.bcd_out !== 16'h0000) begin
      bad++; $display("FAIL reset_bcd_out got=%h want=0000", bus.bcd_out);
    end
    total++;
    if (bus.bcd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_bcd_valid got=%b want=0", bus.bcd_valid);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_first_1234();
    int busy_cnt = 0;
    int pulses = 0;
    int pulse_cyc = -1;
    logic [15:0] seen = 16'hxxxx;
    @(negedge clk);
    bus.freq_valid = 1'b1;
    bus.freq_data  = 12'd1234;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.bcd_out !== exp_out || bus.bcd_valid !== exp_val || bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL first_model cyc=%0d got %h/%b/%b want %h/%b/%b", cyc,
                 bus.bcd_out, bus.bcd_valid, bus.busy, exp_out, exp_val, exp_busy);
      end
      if (bus.busy === 1'b1) begin
        busy_cnt++;
        bus.freq_valid = 1'b0;
        bus.freq_data  = 12'd3210;
      end
      if (bus.bcd_valid === 1'b1) begin
        pulses++;
        pulse_cyc = cyc;
        seen = bus.bcd_out;
      end
    end
    total++;
    if (pulse_cyc != 13) begin
      bad++; $display("FAIL first_latency got=%0d want=13", pulse_cyc);
    end
    total++;
    if (seen !== 16'h1234) begin
      bad++; $display("FAIL first_value got=%h want=1234", seen);
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL first_pulse_width got=%0d want=1", pulses);
    end
    total++;
    if (busy_cnt != 13) begin
      bad++; $display("FAIL first_busy_len got=%0d want=13", busy_cnt);
    end
  endtask

  task automatic test_boundaries();
    int          vals[6] = '{0, 4095, 9, 10, 999, 1000};
    logic [15:0] want[6] = '{16'h0000, 16'h4095, 16'h0009, 16'h0010, 16'h0999, 16'h1000};
    for (int k = 0; k < 6; k++) begin
      logic prev_busy = bus.busy;
      logic started = 1'b0;
      logic done = 1'b0;
      bus.freq_valid = 1'b1;
      bus.freq_data  = 12'(vals[k]);
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
        @(negedge clk);
        total++;
        if (bus.bcd_out !== exp_out || bus.bcd_valid !== exp_val || bus.busy !== exp_busy) begin
          bad++;
          $display("FAIL bound_model v=%0d got %h/%b/%b want %h/%b/%b", vals[k],
                   bus.bcd_out, bus.bcd_valid, bus.busy, exp_out, exp_val, exp_busy);
        end
        if (bus.busy === 1'b1 && prev_busy === 1'b0) begin
          started = 1'b1;
          bus.freq_valid = 1'b0;
          bus.freq_data  = 12'($urandom_range(0, 4095));
        end
        if (started && bus.bcd_valid === 1'b1) begin
          done = 1'b1;
          total++;
          if (bus.bcd_out !== want[k]) begin
            bad++; $display("FAIL bound_value v=%0d got=%h want=%h", vals[k], bus.bcd_out, want[k]);
          end
        end
        prev_busy = bus.busy;
      end
      if (!done) begin
        total++; bad++;
        $display("FAIL bound_timeout v=%0d got=no_pulse want=pulse", vals[k]);
      end
    end
  endtask

  task automatic test_increment();
    logic [15:0] last_out = bus.bcd_out;
    logic [11:0] sampled = 12'd0;
    int          last_pulse = -1;
    int          npulse = 0;
    logic        prev_busy = bus.busy;
    bus.freq_valid = 1'b1;
    bus.freq_data  = 12'd100;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.bcd_out !== exp_out || bus.bcd_valid !== exp_val || bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL incr_model cyc=%0d got %h/%b/%b want %h/%b/%b", cyc,
                 bus.bcd_out, bus.bcd_valid, bus.busy, exp_out, exp_val, exp_busy);
      end
      // The value driven during the sample cycle is still on the bus here.
      if (bus.busy === 1'b1 && prev_busy === 1'b0) sampled = bus.freq_data;
      if (bus.bcd_valid === 1'b1) begin
        npulse++;
        total++;
        if (bus.bcd_out !== to_bcd(int'(sampled))) begin
          bad++; $display("FAIL incr_value got=%h want=%h", bus.bcd_out, to_bcd(int'(sampled)));
        end
        if (npulse >= 2) begin
          total++;
          if (cyc - last_pulse != RC) begin
            bad++; $display("FAIL incr_spacing got=%0d want=%0d", cyc - last_pulse, RC);
          end
        end
        last_pulse = cyc;
        last_out = bus.bcd_out;
      end else begin
        total++;
        if (bus.bcd_out !== last_out) begin
          bad++; $display("FAIL incr_hold got=%h want=%h", bus.bcd_out, last_out);
        end
      end
      prev_busy = bus.busy;
      bus.freq_data = bus.freq_data + 12'd1;
    end
    total++;
    if (npulse < 4) begin
      bad++; $display("FAIL incr_pulses got=%0d want>=4", npulse);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.bcd_out !== exp_out || bus.bcd_valid !== exp_val || bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL rand_model cyc=%0d got %h/%b/%b want %h/%b/%b", cyc,
                 bus.bcd_out, bus.bcd_valid, bus.busy, exp_out, exp_val, exp_busy);
      end
      bus.freq_valid = ($urandom_range(0, 3) != 0);
      bus.freq_data  = 12'($urandom_range(0, 4095));
    end
  endtask

  task automatic test_valid_low();
    int   pulses = 0;
    int   rise_cyc = -1;
    logic prev_busy;
    logic [15:0] seen = 16'hxxxx;
    bus.freq_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && bus.busy !== 1'b0; cyc++) @(negedge clk);
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      bus.freq_data = 12'($urandom_range(0, 4095));
      total++;
      if (bus.busy !== 1'b0 || bus.bcd_valid !== 1'b0) begin
        bad++; $display("FAIL vlow_idle cyc=%0d got busy=%b valid=%b want 0/0", cyc, bus.busy, bus.bcd_valid);
      end
    end
    prev_busy = bus.busy;
    bus.freq_valid = 1'b1;
    bus.freq_data  = 12'd777;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.bcd_out !== exp_out || bus.bcd_valid !== exp_val || bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL vlow_model cyc=%0d got %h/%b/%b want %h/%b/%b", cyc,
                 bus.bcd_out, bus.bcd_valid, bus.busy, exp_out, exp_val, exp_busy);
      end
      if (bus.busy === 1'b1 && prev_busy === 1'b0 && rise_cyc < 0) begin
        rise_cyc = cyc;
        bus.freq_valid = 1'b0;
      end
      if (bus.bcd_valid === 1'b1) begin
        pulses++;
        seen = bus.bcd_out;
      end
      prev_busy = bus.busy;
    end
    total++;
    if (rise_cyc != 1) begin
      bad++; $display("FAIL vlow_start got=%0d want=1", rise_cyc);
    end
    total++;
    if (seen !== 16'h0777) begin
      bad++; $display("FAIL vlow_value got=%h want=0777", seen);
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL vlow_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int          bcnt = 0;
    logic        done = 1'b0;
    logic [11:0] v;
    bus.freq_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && bus.busy !== 1'b0; cyc++) @(negedge clk);
    bus.freq_valid = 1'b1;
    bus.freq_data  = 12'd4000;
    for (int cyc = 0; cyc < 40 && bcnt < 6; cyc++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        bcnt++;
        bus.freq_valid = 1'b0;
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (bcnt != 6) begin
      bad++; $display("FAIL rmid_reach got=%0d want=6", bcnt);
    end
    total++;
    if (bus.bcd_out !== 16'h0000 || bus.bcd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rmid_immediate got %h/%b/%b want 0000/0/0", bus.bcd_out, bus.bcd_valid, bus.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    v = 12'($urandom_range(1, 4095));
    bus.freq_valid = 1'b1;
    bus.freq_data  = v;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge clk);
      bus.freq_valid = 1'b0;
      total++;
      if (bus.bcd_out !== exp_out || bus.bcd_valid !== exp_val || bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL rmid_model cyc=%0d got %h/%b/%b want %h/%b/%b", cyc,
                 bus.bcd_out, bus.bcd_valid, bus.busy, exp_out, exp_val, exp_busy);
      end
      if (bus.bcd_valid === 1'b1) begin
        done = 1'b1;
        total++;
        if (bus.bcd_out !== to_bcd(int'(v))) begin
          bad++; $display("FAIL rmid_value v=%0d got=%h want=%h", v, bus.bcd_out, to_bcd(int'(v)));
        end
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL rmid_timeout got=no_pulse want=pulse");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    test_reset();
    test_first_1234();
    test_boundaries();
    test_increment();
    test_random();
    test_valid_low();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
